// File: rtl/int_ctrl_if.sv
// Purpose: CPU-side signal bundle of the interrupt controller (requests, mask, fetch divert).
// Latency: none; this file only groups signals.
// Backpressure: none here; int_req is held until int_ack or until the request is withdrawn.
interface int_ctrl_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0] irq;
  logic            mask_we;
  logic [7:0]      mask_wd;
  logic            int_ack;
  logic            int_reti;
  logic            int_req;
  logic [9:0]      int_vector;
  logic            int_take;
  logic            in_service;
  logic [NIRQ-1:0] pending;
  logic [7:0]      mask;

  // CPU / request-source side
  modport master (
    output irq, mask_we, mask_wd, int_ack, int_reti,
    input  int_req, int_vector, int_take, in_service, pending, mask
  );

  // Controller side
  modport slave (
    input  irq, mask_we, mask_wd, int_ack, int_reti,
    output int_req, int_vector, int_take, in_service, pending, mask
  );
endinterface

// File: rtl/int_ctrl.sv
// Purpose: fixed-priority, non-nesting interrupt controller that diverts CPU fetch to a vector.
// Latency: irq first sampled at edge k -> pending after k+SYNC_STAGES -> int_req after k+SYNC_STAGES+1.
// Backpressure: int_req/int_vector hold until int_ack (take) or the source loses eligibility (withdraw).
module int_ctrl #(
  parameter int         NIRQ        = 4,
  parameter logic [9:0] VEC_BASE    = 10'h3C0,
  parameter int         VEC_STRIDE  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  int_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  // Only gie and the per-source enables exist; everything else reads back as 0.
  localparam logic [7:0] MASK_KEEP = 8'h80 | 8'((9'd1 << NIRQ) - 9'd1);

  logic [SYNC_STAGES-1:0][NIRQ-1:0] r_sync;
  logic [NIRQ-1:0]                  r_prev;
  logic [NIRQ-1:0]                  r_pending;
  logic [7:0]                       r_mask;
  logic [2:0]                       r_idx;
  logic [9:0]                       r_vec;
  state_t                           r_state;

  state_t          w_state_nxt;
  logic            w_load;
  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_elig;
  logic [NIRQ-1:0] w_idx_hot;
  logic            w_idx_elig;
  logic            w_take;
  logic [2:0]      w_sel;
  logic [9:0]      w_vec;

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_elig     = r_pending & r_mask[NIRQ-1:0] & {NIRQ{r_mask[7]}};
  assign w_idx_hot  = NIRQ'(1) << r_idx;
  assign w_idx_elig = |(w_elig & w_idx_hot);
  assign w_take     = (r_state == S_REQ) & bus.int_ack;
  assign w_vec      = VEC_BASE + 10'(w_sel) * 10'(VEC_STRIDE);

  // Synchronise the async request lines and keep the previous synced value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Pending bits: a taken source is cleared, but a fresh edge in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~(w_take ? w_idx_hot : '0)) | w_rise;
    end
  end

  // Mask register; unimplemented bits are never stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (bus.mask_we) begin
      r_mask <= bus.mask_wd & MASK_KEEP;
    end
  end

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_sel = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = 3'(i);
    end
  end

  // State register plus the source index/vector captured when a request is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_idx <= w_sel;
        r_vec <= w_vec;
      end
    end
  end

  // Next state: ack beats withdrawal; no arbitration while a handler runs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.int_ack)      w_state_nxt = S_SVC;
        else if (!w_idx_elig) w_state_nxt = S_IDLE;
      end
      S_SVC: begin
        if (bus.int_reti) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.int_req    = (r_state == S_REQ);
  assign bus.in_service = (r_state == S_SVC);
  assign bus.int_take   = w_take;
  assign bus.int_vector = r_vec;
  assign bus.pending    = r_pending;
  assign bus.mask       = r_mask;

endmodule
